conv1d_mc_core: RTL
===================

Name: conv1d_mc_core

Overview:
Parametrised multi-channel streaming 1D convolution engine. It is the next-generation datapath behind the conv1d OBI wrapper. NCH channels run in parallel, each with a runtime-selectable tap count up to KMAX, a programmable output shift, and saturation. Control regs drive start/clear/config; status feeds running/done regs and the host interrupt.

Parameters:
DATA_W, 16, signed sample width (input and output)
COEF_W, 16, signed coefficient width
ACC_W, 40, accumulator width; must be >= DATA_W+COEF_W+$clog2(KMAX)
NCH, 4, parallel channels
KMAX, 8, maximum taps per channel
LEN_W, 16, width of output-length counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clear_i  in  1  synchronous soft clear
start_i  in  1  start pulse
cfg_taps_i  in  $clog2(KMAX+1)  taps T, valid range 1..KMAX
cfg_len_i  in  LEN_W  outputs per channel L, valid range >=1
cfg_shift_i  in  $clog2(ACC_W)  arithmetic right shift applied before saturation
coef_we_i  in  1  coefficient write strobe
coef_ch_i  in  $clog2(NCH)  coefficient channel
coef_idx_i  in  $clog2(KMAX)  tap index k
coef_data_i  in  COEF_W  coefficient value
in_valid_i / in_ready_o  in/out  1  input beat handshake
in_data_i  in  NCH*DATA_W  one sample per channel, ch0 in LSBs
out_valid_o / out_ready_i  out/in  1  output handshake
out_data_o  out  NCH*DATA_W  one result per channel
running_o  out  1  high in FILL/RUN
done_o  out  1  sticky completion flag
done_int_o  out  1  one-cycle completion pulse
err_o  out  1  sticky config-error flag

Behaviour:
- Reset: FSM=IDLE; all outputs 0; windows, coefficients, counters and config latches 0.
- FSM states: IDLE, FILL, RUN.
- IDLE, on start_i:
  - T==0, T>KMAX or L==0 → set err_o, remain IDLE.
  - Otherwise latch T/L/shift; clear windows, err_o and done_o.
  - Go to FILL if T>1, else RUN.
- FILL: in_ready_o=1. Each accepted beat shifts the window (w[0]=newest). After T-1 beats → RUN. No output is produced.
- RUN:
  - in_ready_o = !out_valid_o || out_ready_i.
  - Each accepted beat shifts the window and computes, per channel, y = sat_DATA_W( (Σ_{k=0}^{T-1} c[ch][k]·w[k]) >>> shift ). w[0] is the beat being accepted.
  - y is registered into out_data_o with out_valid_o=1 the next cycle (latency 1).
  - out_valid_o/out_data_o hold stable until out_ready_i.
- Completion: the output counter increments on each output handshake. On the handshake of output L: → IDLE, done_o=1, done_int_o=1 for exactly that one cycle.
- Arithmetic:
  - Signed full-precision products, sign-extended to ACC_W.
  - Shift is arithmetic (toward −inf), no rounding.
  - Saturate to [−2^(DATA_W−1), 2^(DATA_W−1)−1].
  - Taps k≥T contribute 0.
- Coefficient writes: accepted only when running_o==0; dropped otherwise. Coefficients persist across start/clear.
- start_i while running_o: ignored.
- clear_i, any state: → IDLE; out_valid_o, done_o, err_o and windows → 0; output counter → 0; coefficients kept. clear_i wins over a same-cycle start_i or coef_we_i.
- in_valid_i in IDLE: in_ready_o=0, data not consumed.

Decomposition:
- Package conv1d_mc_pkg:
  - state enum (IDLE/FILL/RUN)
  - default parameter constants
  - per-channel sample/coef/accumulator typedefs
  - sat/shift helper function
- Sub-module conv1d_mc_mac: one channel's combinational masked dot product + shift + saturate. Instantiated NCH times. FSM, windows, coefficient RAM and output register stay in the top module.

Test Plan:
1. Identity, T=1, c[0]=1, shift=0, L=4, inputs ch0 = 5,−3,7,32767 → outputs 5,−3,7,32767; done_int_o pulses once on the 4th handshake.
2. Moving sum, T=3, c=1,1,1, L=3, ch1 inputs 1,2,3,4,5 → FILL eats 1,2; outputs 6,9,12; running_o low after the last handshake.
3. Backpressure, same as case 2 with out_ready_i low 5 cycles on output 2 → out_data_o stable (9); in_ready_o=0 throughout; no beat lost.
4. Saturation/shift, T=2, c=32767,32767, inputs 32767,32767 → 32767; inputs −32768,−32768 → −32768; shift=16 with inputs 2,2 → 1 (131068>>>16).
5. Config error, start with T=0 then T=KMAX+1, then L=0 → err_o=1, FSM stays IDLE, running_o=0; next valid start clears err_o.
6. Clear mid-run, clear_i while out_valid_o=1 in RUN → next cycle IDLE, out_valid_o=0, done_o=0; restart reproduces case 2 results with coefficients retained.

Source files
------------

// File: rtl/conv1d_mc_pkg.sv
// conv1d_mc_pkg: shared state encoding, default widths, per-channel types
// and the shift/saturate helper for the multi-channel conv1d core.
package conv1d_mc_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_COEF_W = 16;
    localparam int DEF_ACC_W  = 40;
    localparam int DEF_NCH    = 4;
    localparam int DEF_KMAX   = 8;
    localparam int DEF_LEN_W  = 16;

    typedef enum logic [1:0] {IDLE, FILL, RUN} state_e;

    typedef logic signed [DEF_DATA_W-1:0] sample_t;
    typedef logic signed [DEF_COEF_W-1:0] coef_t;
    typedef logic signed [DEF_ACC_W-1:0]  acc_t;

    // Arithmetic shift toward -inf, then clamp to a signed dw-bit range.
    function automatic logic signed [63:0] shift_sat(input logic signed [63:0] acc,
                                                     input int unsigned sh,
                                                     input int unsigned dw);
        logic signed [63:0] s, hi;
        s  = acc >>> sh;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        return (s > hi) ? hi : (s < -hi - 64'sd1) ? -hi - 64'sd1 : s;
    endfunction

endpackage

// File: rtl/conv1d_mc_mac.sv
// conv1d_mc_mac: one channel's masked dot product over the tap window,
// followed by the output shift and saturation. Purely combinational.
module conv1d_mc_mac
    import conv1d_mc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int KMAX   = DEF_KMAX
) (
    input  logic [KMAX*DATA_W-1:0]     win_i,
    input  logic [KMAX*COEF_W-1:0]     coef_i,
    input  logic [$clog2(KMAX+1)-1:0]  taps_i,
    input  logic [$clog2(ACC_W)-1:0]   shift_i,
    output logic [DATA_W-1:0]          y_o
);

    localparam int PW = DATA_W + COEF_W;

    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] acc;

    always_comb begin
        acc  = '0;
        prod = '0;
        for (int k = 0; k < KMAX; k++) begin
            prod = PW'($signed(win_i[k*DATA_W +: DATA_W])) * PW'($signed(coef_i[k*COEF_W +: COEF_W]));
            if (k < int'(taps_i)) acc = acc + ACC_W'(prod);
        end
    end

    assign y_o = DATA_W'(shift_sat(64'(acc), 32'(shift_i), DATA_W));

endmodule

// File: rtl/conv1d_mc_core.sv
// conv1d_mc_core: NCH-channel streaming 1D convolution with runtime tap count,
// output shift and saturation; FSM, windows, coefficients and output register.
module conv1d_mc_core
    import conv1d_mc_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int NCH    = DEF_NCH,
    parameter int KMAX   = DEF_KMAX,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        clear_i,
    input  logic                        start_i,
    input  logic [$clog2(KMAX+1)-1:0]   cfg_taps_i,
    input  logic [LEN_W-1:0]            cfg_len_i,
    input  logic [$clog2(ACC_W)-1:0]    cfg_shift_i,
    input  logic                        coef_we_i,
    input  logic [$clog2(NCH)-1:0]      coef_ch_i,
    input  logic [$clog2(KMAX)-1:0]     coef_idx_i,
    input  logic [COEF_W-1:0]           coef_data_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [NCH*DATA_W-1:0]       in_data_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [NCH*DATA_W-1:0]       out_data_o,
    output logic                        running_o,
    output logic                        done_o,
    output logic                        done_int_o,
    output logic                        err_o
);

    localparam int TW = $clog2(KMAX+1);
    localparam int SW = $clog2(ACC_W);

    state_e state_q, state_d;
    logic [TW-1:0]    taps_q, taps_d, fill_q, fill_d;
    logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
    logic [SW-1:0]    shift_q, shift_d;
    logic [NCH-1:0][KMAX-1:0][DATA_W-1:0] win_q, win_d, win_sh;
    logic [NCH-1:0][KMAX-1:0][COEF_W-1:0] coef_q, coef_d;
    logic [NCH-1:0][DATA_W-1:0] y, out_q, out_d;
    logic out_valid_q, out_valid_d, done_q, done_d, done_int_q, done_int_d, err_q, err_d;
    logic hs, last, bad_cfg;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign win_sh[c] = {win_q[c][KMAX-2:0], in_data_i[c*DATA_W +: DATA_W]};
        conv1d_mc_mac #(
            .DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W), .KMAX(KMAX)
        ) u_mac (
            .win_i   (win_sh[c]),
            .coef_i  (coef_q[c]),
            .taps_i  (taps_q),
            .shift_i (shift_q),
            .y_o     (y[c])
        );
    end

    assign hs      = out_valid_q && out_ready_i;
    assign last    = hs && (cnt_q + LEN_W'(1) == len_q);
    assign bad_cfg = cfg_taps_i == '0 || cfg_taps_i > TW'(KMAX) || cfg_len_i == '0;

    always_comb begin
        state_d     = state_q;
        taps_d      = taps_q;
        len_d       = len_q;
        shift_d     = shift_q;
        fill_d      = fill_q;
        cnt_d       = cnt_q;
        win_d       = win_q;
        coef_d      = coef_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        done_d      = done_q;
        done_int_d  = 1'b0;
        err_d       = err_q;
        in_ready_o  = 1'b0;
        case (state_q)
            IDLE: if (start_i) begin
                if (bad_cfg) err_d = 1'b1;
                else begin
                    taps_d  = cfg_taps_i;
                    len_d   = cfg_len_i;
                    shift_d = cfg_shift_i;
                    win_d   = '0;
                    err_d   = 1'b0;
                    done_d  = 1'b0;
                    cnt_d   = '0;
                    fill_d  = '0;
                    state_d = (cfg_taps_i > TW'(1)) ? FILL : RUN;
                end
            end
            FILL: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    win_d  = win_sh;
                    fill_d = fill_q + TW'(1);
                    if (fill_q + TW'(1) == taps_q - TW'(1)) state_d = RUN;
                end
            end
            RUN: begin
                // The final handshake takes no new beat so nothing is left pending in IDLE.
                in_ready_o = !out_valid_q || (out_ready_i && !last);
                if (hs) begin
                    out_valid_d = 1'b0;
                    cnt_d       = cnt_q + LEN_W'(1);
                end
                if (last) begin
                    state_d    = IDLE;
                    done_d     = 1'b1;
                    done_int_d = 1'b1;
                    cnt_d      = '0;
                end
                if (in_valid_i && in_ready_o) begin
                    win_d       = win_sh;
                    out_valid_d = 1'b1;
                    out_d       = y;
                end
            end
            default: state_d = IDLE;
        endcase
        if (coef_we_i && state_q == IDLE) coef_d[coef_ch_i][coef_idx_i] = coef_data_i;
        if (clear_i) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            done_d      = 1'b0;
            done_int_d  = 1'b0;
            err_d       = 1'b0;
            win_d       = '0;
            cnt_d       = '0;
            fill_d      = '0;
            coef_d      = coef_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            taps_q      <= '0;
            len_q       <= '0;
            shift_q     <= '0;
            fill_q      <= '0;
            cnt_q       <= '0;
            win_q       <= '0;
            coef_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            done_int_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            taps_q      <= taps_d;
            len_q       <= len_d;
            shift_q     <= shift_d;
            fill_q      <= fill_d;
            cnt_q       <= cnt_d;
            win_q       <= win_d;
            coef_q      <= coef_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            done_int_q  <= done_int_d;
            err_q       <= err_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_q;
    assign running_o   = state_q != IDLE;
    assign done_o      = done_q;
    assign done_int_o  = done_int_q;
    assign err_o       = err_q;

endmodule
